// File: rtl/pipelined_adder_pkg.sv
// Shared definitions for the pipelined balanced adder tree: legal parameter
// ranges and the node-width rule used by every tree level.
package pipelined_adder_pkg;

  // Legal parameter ranges for the adder tree.
  localparam int EXPONENT_MIN   = 0;
  localparam int EXPONENT_MAX   = 6;
  localparam int DATA_WIDTH_MIN = 1;
  localparam int DATA_WIDTH_MAX = 32;

  // Width of one tree node at a given level (level 0 = the raw operands).
  // Full precision grows one bit per level; wrap mode keeps the operand width.
  function automatic int node_width(input int data_width, input int level, input int extend);
    return (extend != 0) ? data_width + level : data_width;
  endfunction

endpackage

// File: rtl/adder_stage.sv
// One registered level of the balanced adder tree: N_OUT pairwise sums of
// adjacent input nodes, plus the valid bit and the running overflow flag
// of the transaction that carries them.
module adder_stage
  import pipelined_adder_pkg::*;
#(
  parameter int N_OUT      = 1,
  parameter int DATA_WIDTH = 4,
  parameter int LEVEL      = 1,
  parameter int SIGNED     = 0,
  parameter int EXTEND     = 1,
  localparam int IN_W      = node_width(DATA_WIDTH, LEVEL - 1, EXTEND),
  localparam int OUT_W     = node_width(DATA_WIDTH, LEVEL, EXTEND)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [2*N_OUT*IN_W-1:0] in_data,
  input  logic                   in_valid,
  input  logic                   in_ovf,
  output logic [N_OUT*OUT_W-1:0] out_data,
  output logic                   out_valid,
  output logic                   out_ovf
);

  logic [N_OUT*OUT_W-1:0] sums;
  logic                   any_ovf;
  logic [IN_W-1:0]        op_a;
  logic [IN_W-1:0]        op_b;
  logic [IN_W:0]          ext_a;
  logic [IN_W:0]          ext_b;
  logic [IN_W:0]          sum_full;
  logic                   node_ovf;

  logic [N_OUT*OUT_W-1:0] data_d, data_q;
  logic                   valid_d, valid_q;
  logic                   ovf_d, ovf_q;

  // Pairwise adds: node j is the sum of input nodes 2j and 2j+1, computed
  // one bit wider than the inputs so carry/sign overflow can be read off.
  always_comb begin
    sums     = '0;
    any_ovf  = 1'b0;
    op_a     = '0;
    op_b     = '0;
    ext_a    = '0;
    ext_b    = '0;
    sum_full = '0;
    node_ovf = 1'b0;
    for (int j = 0; j < N_OUT; j++) begin
      op_a     = in_data[(2*j)*IN_W +: IN_W];
      op_b     = in_data[(2*j+1)*IN_W +: IN_W];
      ext_a    = {(SIGNED != 0) & op_a[IN_W-1], op_a};
      ext_b    = {(SIGNED != 0) & op_b[IN_W-1], op_b};
      sum_full = ext_a + ext_b;
      sums[j*OUT_W +: OUT_W] = sum_full[OUT_W-1:0];
      // With sign-extended operands the wide sum is exact, so a signed wrap
      // shows up as the two top bits disagreeing; unsigned wrap is the carry.
      if (EXTEND == 0) begin
        if (SIGNED != 0) begin
          node_ovf = sum_full[IN_W] ^ sum_full[IN_W-1];
        end else begin
          node_ovf = sum_full[IN_W];
        end
        any_ovf = any_ovf | node_ovf;
      end
    end
  end

  // Next-state: load the new level when the pipe advances, otherwise hold.
  // Overflow is rebuilt per transaction so it never leaks into the next one.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    if (en) begin
      data_d  = sums;
      valid_d = in_valid;
      ovf_d   = in_valid & (in_ovf | any_ovf);
    end
  end

  // Stage registers with synchronous reset that drops any in-flight data.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_ovf   = ovf_q;

endmodule

// File: rtl/pipelined_balanced_adder.sv
// Pipelined balanced binary adder tree over 2**EXPONENT operands, one
// register stage per tree level, with a valid/ready stream on both sides.
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// All stages advance together when the output is empty or being taken
// (advance = !outValid || outReady); inReady is exactly that advance, so
// the input side is accepted only when every stage can shift.
module pipelined_balanced_adder
  import pipelined_adder_pkg::*;
#(
  parameter int EXPONENT   = 2,
  parameter int DATA_WIDTH = 4,
  parameter int SIGNED     = 0,
  parameter int EXTEND     = 1,
  localparam int OUT_W     = node_width(DATA_WIDTH, EXPONENT, EXTEND),
  localparam int IN_BITS   = (2**EXPONENT) * DATA_WIDTH
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [IN_BITS-1:0] inputs,
  input  logic               inValid,
  output logic               inReady,
  output logic [OUT_W-1:0]   outputValue,
  output logic               outValid,
  input  logic               outReady,
  output logic               overflow
);

  logic advance;

  assign advance = !outValid || outReady;
  assign inReady = advance;

  if (EXPONENT == 0) begin : g_pass
    // A single operand still gets one register so latency is never zero.
    logic [DATA_WIDTH-1:0] data_d, data_q;
    logic                  valid_d, valid_q;

    // Next-state for the pass-through register.
    always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      if (advance) begin
        data_d  = inputs;
        valid_d = inValid;
      end
    end

    // Pass-through register with synchronous reset.
    always_ff @(posedge clock) begin
      if (reset) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        data_q  <= data_d;
        valid_q <= valid_d;
      end
    end

    assign outputValue = data_q;
    assign outValid    = valid_q;
    assign overflow    = 1'b0;
  end else begin : g_tree
    for (genvar l = 1; l <= EXPONENT; l++) begin : lvl
      localparam int IN_W  = node_width(DATA_WIDTH, l - 1, EXTEND);
      localparam int ST_W  = node_width(DATA_WIDTH, l, EXTEND);
      localparam int N_OUT = 2**(EXPONENT - l);

      logic [2*N_OUT*IN_W-1:0] st_in;
      logic                    st_in_valid;
      logic                    st_in_ovf;
      logic [N_OUT*ST_W-1:0]   st_out;
      logic                    st_out_valid;
      logic                    st_out_ovf;

      // Level 1 reads the operand vector; deeper levels read the level below.
      if (l == 1) begin : g_src
        assign st_in       = inputs;
        assign st_in_valid = inValid;
        assign st_in_ovf   = 1'b0;
      end else begin : g_src
        assign st_in       = lvl[l-1].st_out;
        assign st_in_valid = lvl[l-1].st_out_valid;
        assign st_in_ovf   = lvl[l-1].st_out_ovf;
      end

      adder_stage #(
        .N_OUT      (N_OUT),
        .DATA_WIDTH (DATA_WIDTH),
        .LEVEL      (l),
        .SIGNED     (SIGNED),
        .EXTEND     (EXTEND)
      ) u_stage (
        .clk       (clock),
        .rst       (reset),
        .en        (advance),
        .in_data   (st_in),
        .in_valid  (st_in_valid),
        .in_ovf    (st_in_ovf),
        .out_data  (st_out),
        .out_valid (st_out_valid),
        .out_ovf   (st_out_ovf)
      );
    end

    assign outputValue = lvl[EXPONENT].st_out;
    assign outValid    = lvl[EXPONENT].st_out_valid;
    assign overflow    = lvl[EXPONENT].st_out_ovf;
  end

endmodule

// File: tb/tb_pipelined_balanced_adder.sv
// Directed bench for pipelined_balanced_adder: five configurations share one
// stimulus stream, each checked against hand-computed sums.
module tb_pipelined_balanced_adder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       = 1'b1;
  logic [15:0] in_vec    = '0;
  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  // u0: E=2 W=4 unsigned full precision
  logic u0_in_ready, u0_out_valid, u0_ovf;
  logic [5:0] u0_val;
  // u1: E=2 W=4 unsigned wrap
  logic u1_in_ready, u1_out_valid, u1_ovf;
  logic [3:0] u1_val;
  // u2: E=2 W=4 signed full precision
  logic u2_in_ready, u2_out_valid, u2_ovf;
  logic [5:0] u2_val;
  // u3: E=2 W=4 signed wrap
  logic u3_in_ready, u3_out_valid, u3_ovf;
  logic [3:0] u3_val;
  // u4: E=0 W=4 pass-through
  logic u4_in_ready, u4_out_valid, u4_ovf;
  logic [3:0] u4_val;

  pipelined_balanced_adder #(.EXPONENT(2), .DATA_WIDTH(4), .SIGNED(0), .EXTEND(1)) u0 (
    .clock(clk), .reset(rst), .inputs(in_vec), .inValid(in_valid), .inReady(u0_in_ready),
    .outputValue(u0_val), .outValid(u0_out_valid), .outReady(out_ready), .overflow(u0_ovf));
  pipelined_balanced_adder #(.EXPONENT(2), .DATA_WIDTH(4), .SIGNED(0), .EXTEND(0)) u1 (
    .clock(clk), .reset(rst), .inputs(in_vec), .inValid(in_valid), .inReady(u1_in_ready),
    .outputValue(u1_val), .outValid(u1_out_valid), .outReady(out_ready), .overflow(u1_ovf));
  pipelined_balanced_adder #(.EXPONENT(2), .DATA_WIDTH(4), .SIGNED(1), .EXTEND(1)) u2 (
    .clock(clk), .reset(rst), .inputs(in_vec), .inValid(in_valid), .inReady(u2_in_ready),
    .outputValue(u2_val), .outValid(u2_out_valid), .outReady(out_ready), .overflow(u2_ovf));
  pipelined_balanced_adder #(.EXPONENT(2), .DATA_WIDTH(4), .SIGNED(1), .EXTEND(0)) u3 (
    .clock(clk), .reset(rst), .inputs(in_vec), .inValid(in_valid), .inReady(u3_in_ready),
    .outputValue(u3_val), .outValid(u3_out_valid), .outReady(out_ready), .overflow(u3_ovf));
  pipelined_balanced_adder #(.EXPONENT(0), .DATA_WIDTH(4), .SIGNED(0), .EXTEND(1)) u4 (
    .clock(clk), .reset(rst), .inputs(in_vec[3:0]), .inValid(in_valid), .inReady(u4_in_ready),
    .outputValue(u4_val), .outValid(u4_out_valid), .outReady(out_ready), .overflow(u4_ovf));

  // ---------------- driver tasks ----------------
  // Advance one full cycle; inputs change and outputs are sampled at negedge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  // Bound on the whole run.
  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  // Back-pressure stream: vectors and hand-computed unsigned full-precision sums.
  logic [15:0] bp_vec [6];
  logic [5:0]  bp_exp [6];

  // ---------------- directed sequence ----------------
  initial begin
    int   sent;
    int   rcv;
    int   extra;
    logic took;

    bp_vec[0] = 16'h1234; bp_exp[0] = 6'd10;
    bp_vec[1] = 16'h5678; bp_exp[1] = 6'd26;
    bp_vec[2] = 16'h9ABC; bp_exp[2] = 6'd42;
    bp_vec[3] = 16'hDEF1; bp_exp[3] = 6'd43;
    bp_vec[4] = 16'h0F0F; bp_exp[4] = 6'd30;
    bp_vec[5] = 16'hFFFF; bp_exp[5] = 6'd60;

    // Reset with a valid vector presented: it must not be captured.
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_vec   = 16'hFFFF;
    repeat (3) tick();
    check("rst_u0_valid", u0_out_valid, 1'b0);
    check("rst_u0_value", u0_val, 6'd0);
    check("rst_u0_ovf",   u0_ovf, 1'b0);
    check("rst_u1_ovf",   u1_ovf, 1'b0);
    check("rst_u4_valid", u4_out_valid, 1'b0);
    rst      = 1'b0;
    in_valid = 1'b0;
    check("rst_u0_ready", u0_in_ready, 1'b1);
    tick();
    check("rst_no_capture_a", u0_out_valid, 1'b0);
    tick();
    check("rst_no_capture_b", u0_out_valid, 1'b0);

    // {4,3,2,1}
    in_vec   = 16'h4321;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("t1_u0_not_yet", u0_out_valid, 1'b0);
    check("t1_u4_valid",   u4_out_valid, 1'b1);
    check("t1_u4_value",   u4_val, 4'd1);
    tick();
    check("t1_u0_valid", u0_out_valid, 1'b1);
    check("t1_u0_value", u0_val, 6'd10);
    check("t1_u0_ovf",   u0_ovf, 1'b0);
    check("t1_u1_value", u1_val, 4'd10);
    check("t1_u1_ovf",   u1_ovf, 1'b0);
    check("t1_u2_value", u2_val, 6'd10);
    check("t1_u3_value", u3_val, 4'hA);
    check("t1_u3_ovf",   u3_ovf, 1'b1);
    tick();
    check("t1_u0_bubble", u0_out_valid, 1'b0);

    // {15,15,1,0} then {1,1,1,1} back to back
    in_vec   = 16'hFF10;
    in_valid = 1'b1;
    tick();
    in_vec = 16'h1111;
    tick();
    in_valid = 1'b0;
    check("t2a_u0_value", u0_val, 6'h1F);
    check("t2a_u1_valid", u1_out_valid, 1'b1);
    check("t2a_u1_value", u1_val, 4'hF);
    check("t2a_u1_ovf",   u1_ovf, 1'b1);
    check("t2a_u2_value", u2_val, 6'h3F);
    check("t2a_u3_value", u3_val, 4'hF);
    check("t2a_u3_ovf",   u3_ovf, 1'b0);
    check("t2a_u4_value", u4_val, 4'd1);
    tick();
    check("t2b_u1_valid", u1_out_valid, 1'b1);
    check("t2b_u1_value", u1_val, 4'd4);
    check("t2b_u1_ovf",   u1_ovf, 1'b0);
    check("t2b_u0_value", u0_val, 6'd4);
    tick();

    // {-8,-8,-8,-8} then {7,1,0,0}
    in_vec   = 16'h8888;
    in_valid = 1'b1;
    tick();
    in_vec = 16'h7100;
    tick();
    in_valid = 1'b0;
    check("t3a_u2_value", u2_val, 6'h20);
    check("t3a_u2_ovf",   u2_ovf, 1'b0);
    check("t3a_u0_value", u0_val, 6'h20);
    check("t3a_u1_value", u1_val, 4'd0);
    check("t3a_u1_ovf",   u1_ovf, 1'b1);
    check("t3a_u3_value", u3_val, 4'd0);
    check("t3a_u3_ovf",   u3_ovf, 1'b1);
    tick();
    check("t3b_u3_value", u3_val, 4'h8);
    check("t3b_u3_ovf",   u3_ovf, 1'b1);
    check("t3b_u2_value", u2_val, 6'h08);
    check("t3b_u1_value", u1_val, 4'h8);
    check("t3b_u1_ovf",   u1_ovf, 1'b0);
    tick();

    // Back-pressure: 6-vector stream, outReady low for cycles 3..5.
    sent  = 0;
    rcv   = 0;
    extra = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      out_ready = !(cyc >= 3 && cyc <= 5);
      in_valid  = (sent < 6);
      if (sent < 6) in_vec = bp_vec[sent];
      #1;
      if (u0_out_valid) begin
        if (rcv < 6) check($sformatf("bp_value%0d", rcv), u0_val, bp_exp[rcv]);
        else extra++;
        if (out_ready) rcv++;
        else check("bp_stall_ready", u0_in_ready, 1'b0);
      end
      took = in_valid && u0_in_ready;
      @(posedge clk);
      if (took) sent++;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp_sent",  sent, 6);
    check("bp_recv",  rcv, 6);
    check("bp_extra", extra, 0);

    // Reset in the cycle after two accepts discards both.
    in_vec   = 16'h2222;
    in_valid = 1'b1;
    tick();
    in_vec = 16'h3333;
    tick();
    in_valid = 1'b0;
    rst      = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_valid0", u0_out_valid, 1'b0);
    check("mid_rst_ready",  u0_in_ready, 1'b1);
    tick();
    check("mid_rst_valid1", u0_out_valid, 1'b0);
    tick();
    check("mid_rst_valid2", u0_out_valid, 1'b0);
    in_vec   = 16'h1111;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("post_rst_not_yet", u0_out_valid, 1'b0);
    tick();
    check("post_rst_valid", u0_out_valid, 1'b1);
    check("post_rst_value", u0_val, 6'd4);
    tick();

    // E=0: input 9 appears one cycle later.
    in_vec   = 16'h0009;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("e0_valid", u4_out_valid, 1'b1);
    check("e0_value", u4_val, 4'd9);
    check("e0_ovf",   u4_ovf, 1'b0);
    tick();
    check("e0_bubble", u4_out_valid, 1'b0);

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
